// File: rtl/led_flow_pkg.sv
// Shared encodings for the LED flow controller: command ops, display modes,
// FSM states and the per-mode starting patterns.
package led_flow_pkg;

    typedef enum logic [1:0] {
        OP_STOP     = 2'b00,
        OP_START    = 2'b01,
        OP_PAUSE    = 2'b10,
        OP_SET_MODE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        MODE_FLOW_L = 2'd0,
        MODE_FLOW_R = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [3:0] PAT_FLOW_L = 4'b0001;
    localparam logic [3:0] PAT_FLOW_R = 4'b1000;
    localparam logic [3:0] PAT_BOUNCE = 4'b0001;
    localparam logic [3:0] PAT_BLINK  = 4'b1111;

    function automatic logic [3:0] init_pattern(input mode_e m);
        case (m)
            MODE_FLOW_L: init_pattern = PAT_FLOW_L;
            MODE_FLOW_R: init_pattern = PAT_FLOW_R;
            MODE_BOUNCE: init_pattern = PAT_BOUNCE;
            default:     init_pattern = PAT_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/led_flow_ctrl_tick_gen.sv
// Step prescaler: counts enabled cycles and flags the cycle that reaches
// TICK_MAX; the count wraps to zero by compare on that same edge.
module tick_gen #(
    parameter int              CNT_W    = 25,
    parameter logic [CNT_W-1:0] TICK_MAX = CNT_W'(25'd24_999_999)
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic wrap
);

    logic [CNT_W-1:0] cnt;
    logic             at_max;

    assign at_max = (cnt == TICK_MAX);
    assign wrap   = enable && at_max;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= at_max ? '0 : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: rtl/led_flow_ctrl.sv
// LED bank sequencer: IDLE/RUN/PAUSE FSM, pattern register, bounce direction
// and deferred mode change applied on the next step boundary.
module led_flow_ctrl
    import led_flow_pkg::*;
#(
    parameter int               CNT_W    = 25,
    parameter logic [CNT_W-1:0] TICK_MAX = CNT_W'(25'd24_999_999)
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_mode,
    output logic [3:0] led,
    output logic       step_pulse,
    output logic       busy
);

    logic [1:0] rst_sync;
    logic       rst_i;
    state_e     state, state_nxt;
    mode_e      mode, mode_nxt, pend_mode, pend_mode_nxt;
    logic       pending, pending_nxt;
    logic       dir_up, dir_up_nxt;
    logic [3:0] led_nxt;
    logic       accept, hold, tick_en, tick_clr, wrap;
    op_e        op;

    // Assert immediately, release only after two clean sys_clk edges.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            rst_sync <= 2'b11;
        else
            rst_sync <= {rst_sync[0], 1'b0};
    end
    assign rst_i = rst_sync[1];

    assign op        = op_e'(cmd_op);
    assign cmd_ready = !pending;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != ST_IDLE);

    // STOP/PAUSE win over a coincident step: the counter must not move that edge.
    assign hold     = accept && (op == OP_STOP || op == OP_PAUSE);
    assign tick_en  = (state == ST_RUN) && !hold;
    assign tick_clr = accept && (op == OP_STOP || (op == OP_START && state == ST_IDLE));

    tick_gen #(.CNT_W(CNT_W), .TICK_MAX(TICK_MAX)) u_tick (
        .sys_clk (sys_clk),
        .rst     (rst_i),
        .enable  (tick_en),
        .clear   (tick_clr),
        .wrap    (wrap)
    );

    always_comb begin
        state_nxt     = state;
        mode_nxt      = mode;
        pend_mode_nxt = pend_mode;
        pending_nxt   = pending;
        dir_up_nxt    = dir_up;
        led_nxt       = led;

        if (wrap) begin
            if (pending) begin
                mode_nxt    = pend_mode;
                led_nxt     = init_pattern(pend_mode);
                dir_up_nxt  = 1'b1;
                pending_nxt = 1'b0;
            end else begin
                case (mode)
                    MODE_FLOW_L: led_nxt = {led[2:0], led[3]};
                    MODE_FLOW_R: led_nxt = {led[0], led[3:1]};
                    MODE_BOUNCE: begin
                        if (dir_up && led == 4'b1000) begin
                            led_nxt    = 4'b0100;
                            dir_up_nxt = 1'b0;
                        end else if (!dir_up && led == 4'b0001) begin
                            led_nxt    = 4'b0010;
                            dir_up_nxt = 1'b1;
                        end else begin
                            led_nxt = dir_up ? {led[2:0], 1'b0} : {1'b0, led[3:1]};
                        end
                    end
                    default:     led_nxt = ~led;
                endcase
            end
        end

        if (accept) begin
            case (op)
                OP_STOP: begin
                    state_nxt   = ST_IDLE;
                    led_nxt     = 4'b0000;
                    dir_up_nxt  = 1'b1;
                    pending_nxt = 1'b0;
                end
                OP_START: begin
                    if (state == ST_IDLE) begin
                        state_nxt  = ST_RUN;
                        led_nxt    = init_pattern(mode);
                        dir_up_nxt = 1'b1;
                    end else if (state == ST_PAUSE) begin
                        state_nxt = ST_RUN;
                    end
                end
                OP_PAUSE: begin
                    if (state == ST_RUN)
                        state_nxt = ST_PAUSE;
                end
                default: begin
                    if (state == ST_IDLE) begin
                        mode_nxt = mode_e'(cmd_mode);
                    end else begin
                        pending_nxt   = 1'b1;
                        pend_mode_nxt = mode_e'(cmd_mode);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            mode       <= MODE_FLOW_L;
            pend_mode  <= MODE_FLOW_L;
            pending    <= 1'b0;
            dir_up     <= 1'b1;
            led        <= 4'b0000;
            step_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            mode       <= mode_nxt;
            pend_mode  <= pend_mode_nxt;
            pending    <= pending_nxt;
            dir_up     <= dir_up_nxt;
            led        <= led_nxt;
            step_pulse <= wrap;
        end
    end

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl with TICK_MAX=3 (one step every 4 cycles).
module tb_led_flow_ctrl;
    import led_flow_pkg::*;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [1:0] cmd_mode = 2'b00;
    logic       cmd_ready, step_pulse, busy;
    logic [3:0] led;
    int         errs = 0;
    int         checks = 0;

    led_flow_ctrl #(.CNT_W(25), .TICK_MAX(25'd3)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_mode   (cmd_mode),
        .led        (led),
        .step_pulse (step_pulse),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [1:0] op, input logic [1:0] m);
        chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mode  = m;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Called right after an accept/advance edge; expects the next advance 4 edges on.
    task automatic step_chk(input string tag, input logic [3:0] prev, input logic [3:0] exp);
        tick();
        chk({tag, "_sp_lo"}, {31'd0, step_pulse}, 32'd0);
        tick();
        tick();
        chk({tag, "_hold"}, {28'd0, led}, {28'd0, prev});
        tick();
        chk({tag, "_led"}, {28'd0, led}, {28'd0, exp});
        chk({tag, "_sp"}, {31'd0, step_pulse}, 32'd1);
    endtask

    logic [3:0] flow_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] bnc_seq  [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                 4'b0010, 4'b0001, 4'b0010, 4'b0100};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] prev;

        repeat (3) tick();
        chk("rst_led", {28'd0, led}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sp", {31'd0, step_pulse}, 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // FLOW_L from reset default mode
        send("start_fl", OP_START, 2'd0);
        chk("fl_init", {28'd0, led}, 32'h1);
        chk("fl_busy", {31'd0, busy}, 32'd1);
        chk("fl_sp0", {31'd0, step_pulse}, 32'd0);
        prev = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step_chk("fl", prev, flow_seq[i]);
            prev = flow_seq[i];
        end

        // BOUNCE, mode set while idle
        send("stop1", OP_STOP, 2'd0);
        chk("stop1_led", {28'd0, led}, 32'd0);
        chk("stop1_busy", {31'd0, busy}, 32'd0);
        send("mode_bnc", OP_SET_MODE, MODE_BOUNCE);
        chk("idle_mode_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_mode_led", {28'd0, led}, 32'd0);
        send("start_bnc", OP_START, 2'd0);
        chk("bnc_init", {28'd0, led}, 32'h1);
        prev = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            step_chk("bnc", prev, bnc_seq[i]);
            prev = bnc_seq[i];
        end

        // Pending SET_MODE BLINK while running FLOW_L
        send("stop2", OP_STOP, 2'd0);
        send("mode_fl", OP_SET_MODE, MODE_FLOW_L);
        send("start_fl2", OP_START, 2'd0);
        chk("fl2_init", {28'd0, led}, 32'h1);
        send("mode_blink", OP_SET_MODE, MODE_BLINK);
        chk("pend_rdy1", {31'd0, cmd_ready}, 32'd0);
        chk("pend_led", {28'd0, led}, 32'h1);
        tick();
        chk("pend_rdy2", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("pend_rdy3", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("blink_load", {28'd0, led}, 32'hF);
        chk("blink_sp", {31'd0, step_pulse}, 32'd1);
        chk("pend_clear", {31'd0, cmd_ready}, 32'd1);
        step_chk("blink", 4'b1111, 4'b0000);

        // PAUSE at counter=2 for 10 cycles, then resume
        tick();
        tick();
        send("pause", OP_PAUSE, 2'd0);
        chk("pause_busy", {31'd0, busy}, 32'd1);
        repeat (10) tick();
        chk("pause_led", {28'd0, led}, 32'd0);
        chk("pause_sp", {31'd0, step_pulse}, 32'd0);
        send("resume", OP_START, 2'd0);
        chk("resume_led0", {28'd0, led}, 32'd0);
        tick();
        chk("resume_led1", {28'd0, led}, 32'd0);
        tick();
        chk("resume_adv", {28'd0, led}, 32'hF);
        chk("resume_sp", {31'd0, step_pulse}, 32'd1);

        // STOP on the same edge as a step boundary
        repeat (3) tick();
        send("stop_bnd", OP_STOP, 2'd0);
        chk("stopb_led", {28'd0, led}, 32'd0);
        chk("stopb_busy", {31'd0, busy}, 32'd0);
        chk("stopb_sp", {31'd0, step_pulse}, 32'd0);
        tick();
        chk("stopb_sp2", {31'd0, step_pulse}, 32'd0);

        // Mode retained across STOP; then asynchronous reset mid-cycle
        send("start_keep", OP_START, 2'd0);
        chk("keep_mode", {28'd0, led}, 32'hF);
        send("mode_fr", OP_SET_MODE, MODE_FLOW_R);
        chk("fr_pend", {31'd0, cmd_ready}, 32'd0);
        #3 rst = 1'b1;
        #1;
        chk("arst_led", {28'd0, led}, 32'd0);
        chk("arst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(posedge sys_clk);
        #1 rst = 1'b0;
        repeat (3) tick();
        send("start_post", OP_START, 2'd0);
        chk("post_init", {28'd0, led}, 32'h1);
        step_chk("post", 4'b0001, 4'b0010);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/led_flow_ctrl.md
LED_FLOW_CTRL -- requirements
Module: led_flow_ctrl

Interface
REQ-001 Parameter: TICK_MAX, default 25'd24_999_999; step period is TICK_MAX+1 sys_clk cycles; legal range 1..2^25-1.
REQ-002 Parameter: CNT_W, default 25; width of the tick counter.
REQ-003 sys_clk  in  1  single system clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_ready  out  1  command accept; transfer when cmd_valid && cmd_ready at a rising edge.
REQ-007 cmd_op  in  2  00 STOP, 01 START/RESUME, 10 PAUSE, 11 SET_MODE.
REQ-008 cmd_mode  in  2  SET_MODE operand: 0 FLOW_L, 1 FLOW_R, 2 BOUNCE, 3 BLINK; ignored for other ops.
REQ-009 led  out  4  registered LED bank drive, 1 = on.
REQ-010 step_pulse  out  1  registered one-cycle pulse, 1 cycle after each pattern advance.
REQ-011 busy  out  1  high in RUN or PAUSE.

Function
REQ-012 FSM states: IDLE, RUN, PAUSE.
REQ-013 Each mode has an initial pattern: FLOW_L 0001, FLOW_R 1000, BOUNCE 0001 (direction up), BLINK 1111.
REQ-014 Step sequences:
- FLOW_L: 0001->0010->0100->1000->0001.
- FLOW_R: 1000->0100->0010->0001->1000.
- BOUNCE: 0001->0010->0100->1000->0100->0010->0001->0010..., direction reverses at 1000 and 0001.
- BLINK: 1111<->0000.
REQ-015 IDLE: led=0000, tick counter=0, step_pulse=0.
REQ-016 START accepted in IDLE: next cycle state=RUN, led=initial pattern of the current mode, counter=0.
REQ-017 RUN: counter increments by 1 per cycle; on the cycle counter==TICK_MAX, counter->0, led advances one step, step_pulse=1 the following cycle.
REQ-018 First advance after START occurs at edge TICK_MAX+1 after the accept edge; subsequent advances every TICK_MAX+1 cycles.
REQ-019 PAUSE accepted in RUN: state=PAUSE; led, counter, and BOUNCE direction frozen. PAUSE accepted in IDLE or PAUSE: no effect.
REQ-020 START accepted in PAUSE: state=RUN; counting resumes from the frozen value. START accepted in RUN: no effect.
REQ-021 STOP accepted in any state: next cycle state=IDLE, led=0000, counter=0; current mode is retained.
REQ-022 SET_MODE in IDLE: mode updates immediately; cmd_ready stays high.
REQ-023 SET_MODE in RUN or PAUSE: mode is stored as pending; cmd_ready=0 while pending.
REQ-024 Pending mode is applied at the next step boundary in RUN. At that edge led loads the new mode's initial pattern instead of advancing; step_pulse still fires; pending clears.
REQ-025 STOP clears any pending mode without applying it. Because cmd_ready=0 while pending, STOP is accepted only once pending clears.
REQ-026 cmd_ready = !pending; all other commands are accepted in one cycle.
REQ-027 A step boundary and a command accept in the same cycle: the command takes priority over the step for STOP and PAUSE; the step is discarded and the counter behaves per REQ-019/REQ-021.
REQ-028 Counter arithmetic is CNT_W-bit unsigned; it never exceeds TICK_MAX, and wrap is by compare, not overflow.

Reset
REQ-029 rst asserted: state=IDLE, mode=FLOW_L, pending cleared, counter=0, led=0000, step_pulse=0, busy=0, cmd_ready=1; this takes effect asynchronously, including mid-step.
REQ-030 Release of rst is synchronised to sys_clk before it is used by the FSM.

Structure
REQ-031 Package led_flow_pkg holds the op, mode, and state encodings and the four initial-pattern constants.
REQ-032 Sub-module tick_gen holds the prescaler (inputs: enable, clear; output: wrap at TICK_MAX). led_flow_ctrl holds the FSM, the pattern register, and the pending logic.

Verification (TICK_MAX=3)
REQ-033 Reset, then START in FLOW_L -> led 0001, then 0010/0100/1000/0001 at 4-cycle intervals; step_pulse high 1 cycle after each change.
REQ-034 BOUNCE run for 8 steps -> 0001,0010,0100,1000,0100,0010,0001,0010,0100.
REQ-035 SET_MODE BLINK accepted at counter=1 in FLOW_L -> cmd_ready=0 for 3 cycles; at the boundary led=1111, then 0000 four cycles later.
REQ-036 PAUSE at counter=2 for 10 cycles, then START -> led is unchanged during the pause; the next advance occurs 2 cycles after the resume accept.
REQ-037 STOP coincident with a step boundary -> led=0000 next cycle, busy=0, no step_pulse.
REQ-038 rst asserted mid-run between clock edges -> led=0000 and cmd_ready=1 immediately; after release, START gives FLOW_L 0001.
